// File: rtl/bcd_mul_seq_if.sv
// Handshake and data bundle for the sequential BCD multiplier.
//   start   : request, sampled by the multiplier only while idle
//   a, b    : packed-BCD operands, digit 0 in bits [3:0]
//   busy    : multiplier is working (any state but idle)
//   done    : one-cycle pulse, product/err valid from this cycle
//   product : packed-BCD result, 2*DIGITS digits
//   err     : last operation saw a non-BCD operand digit
// master drives the request side, slave is the multiplier.
interface bcd_mul_seq_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  busy;
  logic                  done;
  logic [8*DIGITS-1:0]   product;
  logic                  err;

  modport master (
    output start, a, b,
    input  busy, done, product, err
  );

  modport slave (
    input  start, a, b,
    output busy, done, product, err
  );
endinterface

// File: rtl/bcd_mul_seq.sv
// Digit-serial BCD multiplier (Horner shift-and-add).
// For each multiplier digit, most significant first, the accumulator is
// shifted left one decimal digit and then the multiplicand is added to it
// as many times as the value of that digit.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : bcd_mul_seq_if slave (start/a/b in, busy/done/product/err out)
module bcd_mul_seq #(
  parameter int DIGITS = 4
) (
  input logic          clk,
  input logic          rst_n,
  bcd_mul_seq_if.slave bus
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = 8 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_ADD   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Ripple BCD adder over 2*DIGITS digits; final carry is dropped because
  // the product always fits.
  function automatic logic [PW-1:0] bcd_add(input logic [PW-1:0] x,
                                            input logic [PW-1:0] y);
    logic          c;
    logic [4:0]    s;
    logic [PW-1:0] r;
    c = 1'b0;
    r = '0;
    for (int k = 0; k < 2 * DIGITS; k++) begin
      s = {1'b0, x[4*k +: 4]} + {1'b0, y[4*k +: 4]} + {4'd0, c};
      if (s > 5'd9) begin
        s = s + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[4*k +: 4] = s[3:0];
    end
    return r;
  endfunction

  // True when any digit of the operand is outside 0..9.
  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (v[4*k +: 4] > 4'd9) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [PW-1:0]   product_q, product_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [3:0]      b_digit_s;
  logic [PW-1:0]   acc_sum_s;

  // Select the multiplier digit addressed by the digit index.
  always_comb begin
    b_digit_s = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        b_digit_s = b_q[4*k +: 4];
      end else begin
        b_digit_s = b_digit_s;
      end
    end
  end

  // Accumulator plus zero-extended multiplicand.
  always_comb begin
    acc_sum_s = bcd_add(acc_q, {{W{1'b0}}, a_q});
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    product_d = product_q;
    err_d     = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d = bus.a;
          b_d = bus.b;
          if (has_bad_digit(bus.a) || has_bad_digit(bus.b)) begin
            product_d = '0;
            err_d     = 1'b1;
            state_d   = S_DONE;
          end else begin
            acc_d   = '0;
            idx_d   = IW'(DIGITS - 1);
            state_d = S_SHIFT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        // The dropped top digit is always zero: the partial product never
        // reaches the top digit before the last shift.
        acc_d   = {acc_q[PW-5:0], 4'b0000};
        cnt_d   = b_digit_s;
        state_d = S_ADD;
      end
      S_ADD: begin
        if (cnt_q != 4'd0) begin
          acc_d = acc_sum_s;
          cnt_d = cnt_q - 4'd1;
        end else if (idx_q == IW'(0)) begin
          product_d = acc_q;
          err_d     = 1'b0;
          state_d   = S_DONE;
        end else begin
          idx_d   = idx_q - IW'(1);
          state_d = S_SHIFT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State, datapath and registered-output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      product_q <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      product_q <= product_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
  assign bus.err     = err_q;

endmodule
